// File: rtl/spi_bootload_pkg.sv
// Shared opcodes, register constants, FSM states and checksum helper
// for the spi_bootload command sequencer.
package spi_bootload_pkg;

   typedef enum logic [1:0] {
      OP_ERASE   = 2'd0,
      OP_PROGRAM = 2'd1,
      OP_READ    = 2'd2,
      OP_REBOOT  = 2'd3
   } cmd_op_e;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FRST,
      S_LOAD,
      S_ARG1,
      S_ARG2,
      S_CMD,
      S_WAIT,
      S_DRAIN,
      S_DONE
   } state_e;

   typedef struct packed {
      logic        en;
      logic        wr;
      logic [1:0]  adr;
      logic [15:0] dat;
   } bus_t;

   localparam logic [7:0]  OPC_ERASE   = 8'hD8;
   localparam logic [7:0]  OPC_PROGRAM = 8'h02;
   localparam logic [7:0]  OPC_READ    = 8'h03;

   localparam logic [15:0] FIFO_RST_W  = 16'h8000;
   localparam logic [15:0] UNLK_ARG1   = 16'h6533;
   localparam logic [15:0] UNLK_ARG2   = 16'h4279;
   localparam logic [15:0] UNLK_CMD    = 16'h93FE;
   localparam logic [15:0] REBOOT_CMD  = 16'hFFFF;

   localparam logic [1:0]  ADR_FIFO    = 2'd0;
   localparam logic [1:0]  ADR_ARG1    = 2'd1;
   localparam logic [1:0]  ADR_ARG2    = 2'd2;
   localparam logic [1:0]  ADR_CMD     = 2'd3;

   function automatic logic [7:0] op_code(cmd_op_e op);
      case (op)
         OP_ERASE:   return OPC_ERASE;
         OP_PROGRAM: return OPC_PROGRAM;
         OP_READ:    return OPC_READ;
         default:    return 8'hFF;
      endcase
   endfunction

   function automatic logic [7:0] chk8(
      logic [15:0] a1,
      logic [15:0] a2,
      logic [7:0]  op
   );
      return a1[15:8] ^ a1[7:0] ^ a2[15:8] ^ a2[7:0] ^ op;
   endfunction

   function automatic bus_t bus_wr(logic [1:0] adr, logic [15:0] dat);
      return '{en: 1'b1, wr: 1'b1, adr: adr, dat: dat};
   endfunction

   function automatic bus_t bus_rd(logic [1:0] adr);
      return '{en: 1'b1, wr: 1'b0, adr: adr, dat: 16'h0000};
   endfunction

endpackage

// File: rtl/spi_bootload_chk.sv
// Combinational command-word checksum over both argument words and the
// opcode; the same function is used by host-side models.
module spi_bootload_chk
   import spi_bootload_pkg::*;
(
   input  logic [15:0] arg1_i,
   input  logic [15:0] arg2_i,
   input  logic [7:0]  op_i,
   output logic [7:0]  chk_o
);

   assign chk_o = chk8(arg1_i, arg2_i, op_i);

endmodule

// File: rtl/spi_bootload_seq.sv
// Turns one flash request into the spi_bootload register sequence.
// Define SPI_BOOTLOAD_SEQ_TIMEOUT_EN to enable the result-wait watchdog.
module spi_bootload_seq
   import spi_bootload_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 240_000_000,
   parameter int unsigned PAGE_BYTES     = 256
)(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic [1:0]  cmd_op_i,
   input  logic [15:0] cmd_page_i,
   input  logic [7:0]  wdat_i,
   input  logic        wvalid_i,
   output logic        wready_o,
   output logic [7:0]  rdat_o,
   output logic        rvalid_o,
   input  logic        rready_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [15:0] status_o,
   output logic        timeout_o,
   output logic [1:0]  bl_adr_o,
   output logic [15:0] bl_dat_o,
   output logic        bl_en_o,
   output logic        bl_wr_o,
   input  logic [15:0] bl_dat_i,
   input  logic        bl_valid_i
);

   state_e      state_q;
   cmd_op_e     op_q;
   logic [15:0] page_q;
   logic        pass_q;
   logic [8:0]  cnt_q;
   logic        rdy_q;
   logic        done_q;
   logic        rvalid_q;
   logic [7:0]  rdat_q;
   logic [15:0] status_q;
   bus_t        bus_q;

   logic [15:0] arg1_w;
   logic [15:0] arg2_w;
   logic [15:0] cmd_w;
   logic [15:0] arg1_first;
   logic [7:0]  chk_w;
   logic        reboot_w;
   logic        load_acc;
   logic        last_byte;

   assign reboot_w  = (op_q == OP_REBOOT);
   assign arg1_w    = {page_q[7:0], 8'h00};
   assign arg2_w    = reboot_w ? (pass_q ? 16'h0000 : UNLK_ARG2)
                               : {8'h00, page_q[15:8]};
   assign cmd_w     = reboot_w ? (pass_q ? REBOOT_CMD : UNLK_CMD)
                               : {chk_w, op_code(op_q)};
   assign arg1_first = (cmd_op_i == OP_REBOOT) ? UNLK_ARG1
                                               : {cmd_page_i[7:0], 8'h00};
   assign load_acc  = (state_q == S_LOAD) & wvalid_i;
   assign last_byte = (cnt_q == 9'(PAGE_BYTES - 1));

   spi_bootload_chk u_chk (
      .arg1_i (arg1_w),
      .arg2_i ({8'h00, page_q[15:8]}),
      .op_i   (op_code(op_q)),
      .chk_o  (chk_w)
   );

`ifdef SPI_BOOTLOAD_SEQ_TIMEOUT_EN
   logic [31:0] tcnt_q;
   logic        tmo_q;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         op_q     <= OP_ERASE;
         page_q   <= '0;
         pass_q   <= 1'b0;
         cnt_q    <= '0;
         rdy_q    <= 1'b0;
         done_q   <= 1'b0;
         rvalid_q <= 1'b0;
         rdat_q   <= '0;
         status_q <= '0;
         bus_q    <= '0;
`ifdef SPI_BOOTLOAD_SEQ_TIMEOUT_EN
         tcnt_q   <= '0;
         tmo_q    <= 1'b0;
`endif
      end else begin
         bus_q  <= '0;
         done_q <= 1'b0;
`ifdef SPI_BOOTLOAD_SEQ_TIMEOUT_EN
         tmo_q  <= 1'b0;
`endif
         unique case (state_q)
            S_IDLE: begin
               rdy_q <= 1'b1;
               if (cmd_valid_i && rdy_q) begin
                  rdy_q  <= 1'b0;
                  op_q   <= cmd_op_e'(cmd_op_i);
                  page_q <= cmd_page_i;
                  pass_q <= 1'b0;
                  cnt_q  <= '0;
                  if (cmd_op_i == OP_PROGRAM || cmd_op_i == OP_READ) begin
                     state_q <= S_FRST;
                     bus_q   <= bus_wr(ADR_FIFO, FIFO_RST_W);
                  end else begin
                     state_q <= S_ARG1;
                     bus_q   <= bus_wr(ADR_ARG1, arg1_first);
                  end
               end
            end
            S_FRST: begin
               if (op_q == OP_PROGRAM) begin
                  state_q <= S_LOAD;
               end else begin
                  state_q <= S_ARG1;
                  bus_q   <= bus_wr(ADR_ARG1, arg1_w);
               end
            end
            // Byte writes go out combinationally; only the count lives here.
            S_LOAD: begin
               if (wvalid_i) begin
                  if (last_byte) begin
                     cnt_q   <= '0;
                     state_q <= S_ARG1;
                     bus_q   <= bus_wr(ADR_ARG1, arg1_w);
                  end else begin
                     cnt_q <= cnt_q + 9'd1;
                  end
               end
            end
            S_ARG1: begin
               state_q <= S_ARG2;
               bus_q   <= bus_wr(ADR_ARG2, arg2_w);
            end
            S_ARG2: begin
               state_q <= S_CMD;
               bus_q   <= bus_wr(ADR_CMD, cmd_w);
            end
            S_CMD: begin
               state_q <= S_WAIT;
               bus_q   <= bus_rd(ADR_CMD);
`ifdef SPI_BOOTLOAD_SEQ_TIMEOUT_EN
               tcnt_q  <= '0;
`endif
            end
            S_WAIT: begin
               if (bl_valid_i) begin
                  status_q <= bl_dat_i;
                  if (reboot_w && !pass_q) begin
                     pass_q  <= 1'b1;
                     state_q <= S_ARG1;
                     bus_q   <= bus_wr(ADR_ARG1, 16'h0000);
                  end else if (op_q == OP_READ) begin
                     state_q <= S_DRAIN;
                     bus_q   <= bus_rd(ADR_FIFO);
                  end else begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end
               end
`ifdef SPI_BOOTLOAD_SEQ_TIMEOUT_EN
               else if (tcnt_q == TIMEOUT_CYCLES - 1) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                  tmo_q   <= 1'b1;
               end else begin
                  tcnt_q <= tcnt_q + 32'd1;
               end
`endif
            end
            S_DRAIN: begin
               if (rvalid_q) begin
                  if (rready_i) begin
                     rvalid_q <= 1'b0;
                     if (last_byte) begin
                        cnt_q   <= '0;
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                     end else begin
                        cnt_q <= cnt_q + 9'd1;
                        bus_q <= bus_rd(ADR_FIFO);
                     end
                  end
               end else if (bl_valid_i) begin
                  rdat_q   <= bl_dat_i[7:0];
                  rvalid_q <= 1'b1;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               rdy_q   <= 1'b1;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign cmd_ready_o = rdy_q;
   assign busy_o      = (state_q != S_IDLE);
   assign done_o      = done_q;
   assign status_o    = status_q;
   assign rdat_o      = rdat_q;
   assign rvalid_o    = rvalid_q;
   assign wready_o    = load_acc;
   assign bl_en_o     = bus_q.en | load_acc;
   assign bl_wr_o     = bus_q.wr | load_acc;
   assign bl_adr_o    = load_acc ? ADR_FIFO : bus_q.adr;
   assign bl_dat_o    = load_acc ? {8'h00, wdat_i} : bus_q.dat;

`ifdef SPI_BOOTLOAD_SEQ_TIMEOUT_EN
   assign timeout_o = tmo_q;
`else
   assign timeout_o = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_spi_bootload_seq.sv
// Bench for spi_bootload_seq: expected bus transactions from the flash
// address/opcode rules, compared by one negedge monitor.
module tb_spi_bootload_seq;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        cmd_valid_i;
   logic        cmd_ready_o;
   logic [1:0]  cmd_op_i;
   logic [15:0] cmd_page_i;
   logic [7:0]  wdat_i;
   logic        wvalid_i;
   logic        wready_o;
   logic [7:0]  rdat_o;
   logic        rvalid_o;
   logic        rready_i;
   logic        busy_o;
   logic        done_o;
   logic [15:0] status_o;
   logic        timeout_o;
   logic [1:0]  bl_adr_o;
   logic [15:0] bl_dat_o;
   logic        bl_en_o;
   logic        bl_wr_o;
   logic [15:0] bl_dat_i;
   logic        bl_valid_i;

   always #5 clk = ~clk;

   spi_bootload_seq #(.TIMEOUT_CYCLES(50), .PAGE_BYTES(256)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
      .cmd_op_i(cmd_op_i), .cmd_page_i(cmd_page_i),
      .wdat_i(wdat_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
      .rdat_o(rdat_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
      .busy_o(busy_o), .done_o(done_o), .status_o(status_o),
      .timeout_o(timeout_o),
      .bl_adr_o(bl_adr_o), .bl_dat_o(bl_dat_o),
      .bl_en_o(bl_en_o), .bl_wr_o(bl_wr_o),
      .bl_dat_i(bl_dat_i), .bl_valid_i(bl_valid_i)
   );

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   logic [18:0] exp_q[$];
   int          acc_cyc, first_cyc, rd3_cyc, a1_cyc, vcyc, hcyc;
   int          wr_cnt, rx_idx, done_cnt, rd_i;
   logic        first_pend = 1'b0;
   logic [15:0] last_cmd;
   int          cur_op;
   logic        expect_tmo = 1'b0;
   logic        resp_en = 1'b1;
   logic [15:0] resp_status;

   function automatic void chk(string name, logic [31:0] act,
                               logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endfunction

   // Model: 32-bit flash byte address split into two argument words.
   function automatic logic [15:0] model_cmd(int op, logic [15:0] page);
      logic [31:0] addr;
      logic [7:0]  opc;
      addr = {8'h00, page, 8'h00};
      opc  = (op == 0) ? 8'hD8 : (op == 1) ? 8'h02 : 8'h03;
      return {addr[31:24] ^ addr[23:16] ^ addr[15:8] ^ addr[7:0] ^ opc,
              opc};
   endfunction

   task automatic build_expect(int op, logic [15:0] page);
      logic [31:0] addr;
      addr = {8'h00, page, 8'h00};
      exp_q.delete();
      if (op == 1 || op == 2) exp_q.push_back({1'b1, 2'd0, 16'h8000});
      if (op == 1)
         for (int i = 0; i < 256; i++)
            exp_q.push_back({1'b1, 2'd0, 8'h00, 8'(i)});
      if (op == 3) begin
         exp_q.push_back({1'b1, 2'd1, 16'h6533});
         exp_q.push_back({1'b1, 2'd2, 16'h4279});
         exp_q.push_back({1'b1, 2'd3, 16'h93FE});
         exp_q.push_back({1'b0, 2'd3, 16'h0000});
         exp_q.push_back({1'b1, 2'd1, 16'h0000});
         exp_q.push_back({1'b1, 2'd2, 16'h0000});
         exp_q.push_back({1'b1, 2'd3, 16'hFFFF});
      end else begin
         exp_q.push_back({1'b1, 2'd1, addr[15:0]});
         exp_q.push_back({1'b1, 2'd2, addr[31:16]});
         exp_q.push_back({1'b1, 2'd3, model_cmd(op, page)});
      end
      exp_q.push_back({1'b0, 2'd3, 16'h0000});
      if (op == 2)
         for (int i = 0; i < 256; i++)
            exp_q.push_back({1'b0, 2'd0, 16'h0000});
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(posedge clk);
      #1;
      rready_i = 1'($urandom_range(0, 1));
   end

   // Register-port responder: two-cycle read latency.
   initial forever begin
      logic [1:0] a;
      @(negedge clk);
      if (!rst_i && resp_en && bl_en_o && !bl_wr_o) begin
         a = bl_adr_o;
         @(posedge clk);
         @(posedge clk);
         #1;
         bl_valid_i = 1'b1;
         if (a == 2'd3) begin
            bl_dat_i = resp_status;
            rd_i = 0;
         end else begin
            bl_dat_i = {8'hEE, 8'(rd_i)};
            rd_i++;
         end
         @(posedge clk);
         #1;
         bl_valid_i = 1'b0;
         bl_dat_i = 16'h0000;
      end
   end

   initial forever begin
      logic [18:0] e;
      @(negedge clk);
      if (rst_i) begin
         exp_q.delete();
         first_pend = 1'b0;
      end else begin
         if (cmd_valid_i && cmd_ready_o) begin
            acc_cyc = cyc;
            first_pend = 1'b1;
            wr_cnt = 0;
            done_cnt = 0;
         end
         if (bl_en_o) begin
            if (first_pend) begin
               chk("first_strobe_lat", cyc - acc_cyc, 1);
               first_pend = 1'b0;
               first_cyc = cyc;
            end
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL bus_extra: got wr=%0d adr=%0d dat=%h want none",
                        bl_wr_o, bl_adr_o, bl_dat_o);
            end else begin
               e = exp_q.pop_front();
               chk("bus_wr", 32'(bl_wr_o), 32'(e[18]));
               chk("bus_adr", 32'(bl_adr_o), 32'(e[17:16]));
               if (e[18]) chk("bus_dat", 32'(bl_dat_o), 32'(e[15:0]));
            end
            if (bl_wr_o && bl_adr_o == 2'd1) a1_cyc = cyc;
            if (bl_wr_o && bl_adr_o == 2'd3) last_cmd = bl_dat_o;
            if (!bl_wr_o && bl_adr_o == 2'd3) begin
               chk("arg_to_wait_spacing", cyc - a1_cyc, 3);
               rd3_cyc = cyc;
               rx_idx = 0;
            end
         end
         if (wvalid_i && wready_o) wr_cnt++;
         if (bl_valid_i) vcyc = cyc;
         if (rvalid_o && rready_i) begin
            chk("rdat", 32'(rdat_o), 32'(rx_idx[7:0]));
            rx_idx++;
            hcyc = cyc;
         end
         if (done_o) begin
            done_cnt++;
            if (expect_tmo) begin
               chk("tmo_done_cyc", cyc - rd3_cyc, 50);
               chk("timeout_hi", 32'(timeout_o), 1);
            end else begin
               chk("done_lat", cyc - ((cur_op == 2) ? hcyc : vcyc), 1);
               chk("timeout_lo", 32'(timeout_o), 0);
            end
            chk("bus_left", exp_q.size(), 0);
         end
      end
   end

   task automatic check_reset(string tag);
      chk({tag, "_ready"}, 32'(cmd_ready_o), 0);
      chk({tag, "_busy"}, 32'(busy_o), 0);
      chk({tag, "_done"}, 32'(done_o), 0);
      chk({tag, "_status"}, 32'(status_o), 0);
      chk({tag, "_wready"}, 32'(wready_o), 0);
      chk({tag, "_rvalid"}, 32'(rvalid_o), 0);
      chk({tag, "_rdat"}, 32'(rdat_o), 0);
      chk({tag, "_bl_en"}, 32'(bl_en_o), 0);
      chk({tag, "_tmo"}, 32'(timeout_o), 0);
   endtask

   task automatic issue(int op, logic [15:0] page);
      int n;
      @(posedge clk);
      #1;
      cmd_valid_i = 1'b1;
      cmd_op_i = 2'(op);
      cmd_page_i = page;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!cmd_ready_o && n < 50);
      chk("accept", 32'(cmd_ready_o), 1);
      @(posedge clk);
      #1;
      cmd_valid_i = 1'b0;
      cmd_page_i = ~page;
      cmd_op_i = 2'(op + 1);
      @(negedge clk);
      chk("ready_drop", 32'(cmd_ready_o), 0);
      chk("busy_hi", 32'(busy_o), 1);
   endtask

   task automatic send_bytes(bit gaps, int nb);
      int n;
      for (int i = 0; i < nb; i++) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            wvalid_i = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
         wdat_i = 8'(i);
         wvalid_i = 1'b1;
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!wready_o && n < 2000);
         if (!wready_o) begin
            chk("byte_accept", 32'(wready_o), 1);
            wvalid_i = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
      end
      wvalid_i = 1'b0;
   endtask

   task automatic wait_done(int maxc);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done_o && n < maxc);
      chk("done_seen", 32'(done_o), 1);
      @(negedge clk);
      chk("done_pulse", 32'(done_o), 0);
      chk("idle_ready", 32'(cmd_ready_o), 1);
      chk("idle_busy", 32'(busy_o), 0);
      chk("done_count", done_cnt, 1);
   endtask

   task automatic run_op(int op, logic [15:0] page, logic [15:0] st,
                         bit gaps);
      cur_op = op;
      resp_status = st;
      build_expect(op, page);
      issue(op, page);
      if (op == 1) begin
         fork
            send_bytes(gaps, 256);
            wait_done(20000);
         join
         chk("wready_count", wr_cnt, 256);
      end else begin
         wait_done(20000);
      end
      if (op == 2) chk("rx_count", rx_idx, 256);
      chk("status", 32'(status_o), 32'(st));
   endtask

   initial begin
      rst_i = 1'b1;
      cmd_valid_i = 1'b0;
      cmd_op_i = 2'd0;
      cmd_page_i = 16'h0000;
      wdat_i = 8'h00;
      wvalid_i = 1'b0;
      bl_dat_i = 16'h0000;
      bl_valid_i = 1'b0;
      rready_i = 1'b0;
      cur_op = 0;
      resp_status = 16'h0000;
      repeat (3) @(posedge clk);
      #2;
      check_reset("rst");
      @(posedge clk);
      #1;
      rst_i = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("ready_after_rst", 32'(cmd_ready_o), 1);

      chk("model_erase_cmd", 32'(model_cmd(0, 16'h0100)), 32'h0000_D9D8);
      chk("model_prog_cmd", 32'(model_cmd(1, 16'h0100)), 32'h0000_0302);

      run_op(0, 16'h0100, 16'h1234, 1'b0);
      chk("erase_cmd_word", 32'(last_cmd), 32'h0000_D9D8);

      run_op(1, 16'h0100, 16'hC0DE, 1'b1);
      chk("prog_cmd_word", 32'(last_cmd), 32'h0000_0302);

      run_op(1, 16'h0203, 16'h0042, 1'b0);
      chk("prog_bus_time", rd3_cyc - first_cyc, 260);

      run_op(2, 16'h0100, 16'h0BAD, 1'b0);
      chk("read_cmd_word", 32'(last_cmd), 32'h0000_0203);

      run_op(3, 16'h0000, 16'h5A5A, 1'b0);
      chk("reboot_cmd_word", 32'(last_cmd), 32'h0000_FFFF);

      cur_op = 1;
      build_expect(1, 16'h0100);
      issue(1, 16'h0100);
      send_bytes(1'b0, 100);
      wdat_i = 8'd100;
      wvalid_i = 1'b1;
      @(posedge clk);
      #2;
      rst_i = 1'b1;
      #1;
      check_reset("mid_rst");
      wvalid_i = 1'b0;
      @(posedge clk);
      #1;
      rst_i = 1'b0;
      run_op(0, 16'h0100, 16'hBEEF, 1'b0);
      chk("post_rst_cmd", 32'(last_cmd), 32'h0000_D9D8);

      resp_en = 1'b0;
      cur_op = 0;
      build_expect(0, 16'h0042);
`ifdef SPI_BOOTLOAD_SEQ_TIMEOUT_EN
      expect_tmo = 1'b1;
      issue(0, 16'h0042);
      wait_done(500);
      chk("tmo_status_kept", 32'(status_o), 32'h0000_BEEF);
      expect_tmo = 1'b0;
`else
      issue(0, 16'h0042);
      repeat (200) @(negedge clk);
      chk("wait_busy", 32'(busy_o), 1);
      chk("wait_no_done", done_cnt, 0);
      chk("wait_bus_all", exp_q.size(), 0);
      @(posedge clk);
      #1;
      rst_i = 1'b1;
      @(posedge clk);
      #1;
      rst_i = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
